// File: rtl/duck_round_ctl_if.sv
// Game-side bundle for the duck round controller.
// master: game control (drives enable/kill); slave: duck_round_ctl.
interface duck_round_if;
  logic       game_enable;
  logic       target_killed;
  logic       hunt_start;
  logic       escape_pulse;
  logic [6:0] enemy_score;
  logic [6:0] round_num;
  logic       rounds_done;

  modport master (
    output game_enable,
    output target_killed,
    input  hunt_start,
    input  escape_pulse,
    input  enemy_score,
    input  round_num,
    input  rounds_done
  );

  modport slave (
    input  game_enable,
    input  target_killed,
    output hunt_start,
    output escape_pulse,
    output enemy_score,
    output round_num,
    output rounds_done
  );
endinterface

// File: rtl/duck_round_ctl.sv
// Duck round sequencer: spawn delay, flight/escape timeout, fall delay,
// escape scoring and round counting over ROUNDS flights per game.
// Ports: clk, rst (async, active-low), bus (duck_round_if.slave):
//   in  game_enable, target_killed
//   out hunt_start, escape_pulse, enemy_score[6:0], round_num[6:0],
//       rounds_done
// Option: DUCK_ROUND_SPEEDUP_EN halves flight time in the second half
// of the game.
module duck_round_ctl #(
  parameter int unsigned ROUNDS        = 20,
  parameter logic [31:0] RESPAWN_TICKS = 32'd32_500_000,
  parameter logic [31:0] ESCAPE_TICKS  = 32'd260_000_000,
  parameter logic [31:0] FALL_TICKS    = 32'd65_000_000
) (
  input logic         clk,
  input logic         rst,
  duck_round_if.slave bus
);

  localparam logic [31:0] MAX_A =
    (RESPAWN_TICKS > ESCAPE_TICKS) ? RESPAWN_TICKS : ESCAPE_TICKS;
  localparam logic [31:0] MAX_B =
    (MAX_A > FALL_TICKS) ? MAX_A : FALL_TICKS;
  localparam int TW = $clog2({1'b0, MAX_B} + 33'd1);

  typedef logic [TW-1:0] tick_t;

  localparam tick_t RESP_LD = tick_t'(RESPAWN_TICKS - 32'd1);
  localparam tick_t ESC_LD  = tick_t'(ESCAPE_TICKS - 32'd1);
  localparam tick_t FALL_LD = tick_t'(FALL_TICKS - 32'd1);

`ifdef DUCK_ROUND_SPEEDUP_EN
  localparam tick_t ESC_FAST_LD =
    tick_t'((ESCAPE_TICKS >> 1) - 32'd1);
  localparam logic [6:0] RND_HALF = 7'(ROUNDS / 2);
`endif

  localparam logic [6:0] RND_MAX   = 7'(ROUNDS);
  localparam logic [6:0] SCORE_MAX = 7'd99;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_FLY,
    S_FALL,
    S_ESC,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  tick_t      tick_q, tick_d;
  logic       hunt_q, hunt_d;
  logic       esc_q, esc_d;
  logic [6:0] score_q, score_d;
  logic [6:0] round_q, round_d;
  logic       done_q, done_d;

  logic [6:0] rnd_next;
  tick_t      fly_ld;

  // Round number after launch; pinned at ROUNDS so it never wraps.
  always_comb begin
    rnd_next = round_q;
    if (round_q < RND_MAX) begin
      rnd_next = round_q + 7'd1;
    end
  end

  always_comb begin
    fly_ld = ESC_LD;
`ifdef DUCK_ROUND_SPEEDUP_EN
    if (rnd_next > RND_HALF) begin
      fly_ld = ESC_FAST_LD;
    end
`else
    fly_ld = ESC_LD;
`endif
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    score_d = score_q;
    round_d = round_q;
    done_d  = done_q;

    if (!bus.game_enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SPAWN;
          tick_d  = RESP_LD;
          score_d = '0;
          round_d = '0;
          done_d  = 1'b0;
        end
        S_SPAWN: begin
          if (tick_q == '0) begin
            state_d = S_FLY;
            round_d = rnd_next;
            tick_d  = fly_ld;
          end else begin
            tick_d = tick_q - tick_t'(1);
          end
        end
        S_FLY: begin
          // A kill on the timeout cycle still counts as a kill.
          if (bus.target_killed) begin
            state_d = S_FALL;
            tick_d  = FALL_LD;
          end else if (tick_q == '0) begin
            state_d = S_ESC;
            if (score_q < SCORE_MAX) begin
              score_d = score_q + 7'd1;
            end
          end else begin
            tick_d = tick_q - tick_t'(1);
          end
        end
        S_FALL: begin
          if (tick_q == '0) begin
            if (round_q >= RND_MAX) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_SPAWN;
              tick_d  = RESP_LD;
            end
          end else begin
            tick_d = tick_q - tick_t'(1);
          end
        end
        S_ESC: begin
          if (round_q >= RND_MAX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SPAWN;
            tick_d  = RESP_LD;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered copies of the next state.
    hunt_d = (state_d == S_FLY);
    esc_d  = (state_d == S_ESC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      hunt_q  <= 1'b0;
      esc_q   <= 1'b0;
      score_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      hunt_q  <= hunt_d;
      esc_q   <= esc_d;
      score_q <= score_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign bus.hunt_start   = hunt_q;
  assign bus.escape_pulse = esc_q;
  assign bus.enemy_score  = score_q;
  assign bus.round_num    = round_q;
  assign bus.rounds_done  = done_q;

endmodule

// File: tb/tb_duck_round_ctl.sv
// Randomized scoreboard bench for duck_round_ctl.
// Expected events come from round timing arithmetic.
module tb_duck_round_ctl;

`ifdef DUCK_ROUND_SPEEDUP_EN
  localparam int ROUNDS = 4;
  localparam bit FAST   = 1'b1;
`else
  localparam int ROUNDS = 3;
  localparam bit FAST   = 1'b0;
`endif
  localparam int RESP = 5;
  localparam int ESC  = 20;
  localparam int FALL = 8;

  localparam int EV_FALL   = 0;
  localparam int EV_ESC    = 1;
  localparam int EV_LAUNCH = 2;
  localparam int EV_DONE   = 3;

  typedef struct {
    int kind;
    int cyc;
    int score;
    int rnd;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   score_m = 0;
  ev_t  q[$];
  logic p_h = 1'b0;
  logic p_d = 1'b0;

  duck_round_if bus();

  duck_round_ctl #(
    .ROUNDS       (ROUNDS),
    .RESPAWN_TICKS(32'(RESP)),
    .ESCAPE_TICKS (32'(ESC)),
    .FALL_TICKS   (32'(FALL))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int flight_len(input int r);
    if (FAST && r > ROUNDS / 2) return ESC / 2;
    return ESC;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input int s,
                      input int r);
    ev_t e;
    e.kind = k; e.cyc = c; e.score = s; e.rnd = r;
    q.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cyc %0d, none expected",
               kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          e.score != int'(bus.enemy_score) ||
          e.rnd != int'(bus.round_num)) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d score %0d round %0d, expected kind %0d cyc %0d score %0d round %0d",
                 kind, cyc, bus.enemy_score, bus.round_num,
                 e.kind, e.cyc, e.score, e.rnd);
      end
    end
  endtask

  // Monitor: turns output edges into events and checks them in order.
  always @(negedge clk) begin
    if (!rst) begin
      p_h = 1'b0;
      p_d = 1'b0;
    end else begin
      if (p_h && !bus.hunt_start) observe(EV_FALL);
      if (bus.escape_pulse) observe(EV_ESC);
      if (!p_h && bus.hunt_start) observe(EV_LAUNCH);
      if (!p_d && bus.rounds_done) observe(EV_DONE);
      checks++;
      if (int'(bus.round_num) > ROUNDS) begin
        errors++;
        $display("FAIL round_limit: got %0d expected <= %0d",
                 bus.round_num, ROUNDS);
      end
      p_h = bus.hunt_start;
      p_d = bus.rounds_done;
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_kill_at(input int c);
    wait_until(c);
    bus.target_killed = 1'b1;
    wait_until(c + 1);
    bus.target_killed = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_hunt"}, int'(bus.hunt_start), 0);
    check({nm, "_esc"}, int'(bus.escape_pulse), 0);
    check({nm, "_score"}, int'(bus.enemy_score), 0);
    check({nm, "_round"}, int'(bus.round_num), 0);
    check({nm, "_done"}, int'(bus.rounds_done), 0);
  endtask

  task automatic start_game(output int e);
    e = cyc + 1;
    bus.game_enable = 1'b1;
    score_m = 0;
    wait_until(e);
    check_zero("game_start");
  endtask

  task automatic run_game(input int abort_r, input int rst_r,
                          input int k1, input int k2,
                          input bit no_kill);
    int s, l, k, fl, endc, d;
    start_game(s);
    for (int r = 1; r <= ROUNDS; r++) begin
      l  = s + RESP;
      fl = flight_len(r);
      push(EV_LAUNCH, l, score_m, r);
      if (r == abort_r) begin
        d = $urandom_range(1, fl - 1);
        push(EV_FALL, l + d, score_m, r);
        wait_until(l + d - 1);
        bus.game_enable = 1'b0;
        wait_until(l + d + 2);
        check("abort_round_held", int'(bus.round_num), r);
        check("abort_score_held", int'(bus.enemy_score), score_m);
        check("abort_hunt", int'(bus.hunt_start), 0);
        wait_until(cyc + 4);
        return;
      end
      if (r == rst_r) begin
        wait_until(l + 3);
        #2;
        rst = 1'b0;
        #1;
        check_zero("mid_reset");
        q.delete();
        bus.game_enable = 1'b0;
        @(posedge clk);
        #1;
        wait_until(cyc + 2);
        rst = 1'b1;
        wait_until(cyc + 2);
        check_zero("post_reset_idle");
        return;
      end
      if (no_kill) k = 0;
      else if (r == 1 && k1 >= 0) k = k1;
      else if (r == 2 && k2 >= 0) k = k2;
      else begin
        case ($urandom_range(0, 2))
          0: k = 0;
          1: k = $urandom_range(1, fl - 1);
          default: k = fl;
        endcase
      end
      if (k > 0) begin
        push(EV_FALL, l + k, score_m, r);
        endc = l + k + FALL;
      end else begin
        score_m = (score_m < 99) ? score_m + 1 : 99;
        push(EV_FALL, l + fl, score_m, r);
        push(EV_ESC, l + fl, score_m, r);
        endc = l + fl + 1;
      end
      if (r == ROUNDS) push(EV_DONE, endc, score_m, r);
      if ($urandom_range(0, 1) == 1) pulse_kill_at(s + 1);
      if (k > 0) begin
        pulse_kill_at(l + k - 1);
        if ($urandom_range(0, 1) == 1) pulse_kill_at(l + k + 1);
      end
      s = endc;
    end
    wait_until(s + 3);
    check("done_hold", int'(bus.rounds_done), 1);
    check("done_round", int'(bus.round_num), ROUNDS);
    check("done_score", int'(bus.enemy_score), score_m);
    check("done_hunt", int'(bus.hunt_start), 0);
    bus.game_enable = 1'b0;
    wait_until(cyc + 3);
    check("done_after_disable", int'(bus.rounds_done), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.game_enable   = 1'b0;
    bus.target_killed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    run_game(0, 0, 7, ESC, 1'b0);
    run_game(0, 0, -1, -1, 1'b1);
    run_game(2, 0, -1, -1, 1'b0);
    run_game(0, 0, -1, -1, 1'b0);
    run_game(0, 2, -1, -1, 1'b0);
    run_game(0, 0, -1, -1, 1'b0);
    wait_until(cyc + 5);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/duck_round_ctl.md
DUCK_ROUND_CTL -- requirements
Module: duck_round_ctl

Interface
REQ-001 Parameter ROUNDS, default 20: duck flights per game, range 1..99.
REQ-002 Parameter RESPAWN_TICKS, default 32'd32_500_000: cycles between rounds before the next duck launches, minimum 1.
REQ-003 Parameter ESCAPE_TICKS, default 32'd260_000_000: cycles a duck flies before escaping, minimum 2.
REQ-004 Parameter FALL_TICKS, default 32'd65_000_000: cycles a killed duck stays drawn before the round closes, minimum 1.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 game_enable  in  1  game phase active, level input from the game control FSM.
REQ-008 target_killed  in  1  one-cycle pulse: duck hit.
REQ-009 hunt_start  out  1  duck in flight, drives duck motion control.
REQ-010 escape_pulse  out  1  one-cycle pulse: duck escaped.
REQ-011 enemy_score  out  7  escaped-duck count, binary, feeds the 2-digit display.
REQ-012 round_num  out  7  current round, 1-based; 0 before the first launch.
REQ-013 rounds_done  out  1  all ROUNDS flights finished.

Function
REQ-014 The block SHALL implement the states IDLE, SPAWN_WAIT, FLYING, FALLING, ESCAPED and DONE, with one shared down-counter tick_cnt of width $clog2(max parameter + 1).
REQ-015 IDLE with game_enable=1: next state SPAWN_WAIT, with enemy_score=0, round_num=0, rounds_done=0 and tick_cnt=RESPAWN_TICKS-1.
REQ-016 SPAWN_WAIT: tick_cnt decrements each cycle; at 0 the next state is FLYING, round_num increments, tick_cnt loads ESCAPE_TICKS-1 (or the value set by REQ-028).
REQ-017 FLYING: hunt_start=1 (registered, asserted on the first FLYING cycle); tick_cnt decrements each cycle.
REQ-018 FLYING with target_killed=1: next state FALLING, tick_cnt=FALL_TICKS-1; hunt_start deasserts on the next cycle.
REQ-019 FLYING with tick_cnt=0 and no kill: next state ESCAPED.
REQ-020 Kill and timeout in the same cycle: the kill wins and no escape is counted.
REQ-021 ESCAPED lasts one cycle: escape_pulse=1, enemy_score increments and saturates at 99, hunt_start=0.
REQ-022 After FALLING reaches tick_cnt=0, or after ESCAPED: if round_num==ROUNDS the next state is DONE; otherwise SPAWN_WAIT with tick_cnt=RESPAWN_TICKS-1.
REQ-023 DONE: rounds_done=1 and hunt_start=0; the block holds there until game_enable=0.
REQ-024 game_enable=0 in any state: next state IDLE, hunt_start=0, escape_pulse=0; enemy_score, round_num and rounds_done hold their values.
REQ-025 target_killed outside FLYING SHALL be ignored.
REQ-026 round_num SHALL never exceed ROUNDS and SHALL never wrap.

Reset
REQ-027 Asserting rst (low) at any time, including mid-round, forces IDLE with every output and tick_cnt at 0; operation resumes on the first edge after release, gated by game_enable.

Configuration
REQ-028 Macro DUCK_ROUND_SPEEDUP_EN:
- Defined: for rounds where round_num (after increment) > ROUNDS/2, FLYING loads tick_cnt with (ESCAPE_TICKS>>1)-1.
- Undefined: every round loads ESCAPE_TICKS-1.
- All other behaviour is identical in both builds.

Verification
All scenarios use ROUNDS=3, RESPAWN_TICKS=5, ESCAPE_TICKS=20, FALL_TICKS=8 unless stated.
REQ-029 Reset release, game_enable=1 at cycle 0 -> hunt_start rises at cycle 6, round_num=1.
REQ-030 No kills for a full game -> escape_pulse after exactly 20 FLYING cycles each round, enemy_score=3, rounds_done=1, round_num=3.
REQ-031 target_killed in FLYING cycle 7 of round 1 -> hunt_start low next cycle, FALLING for 8 cycles, next launch 5 cycles later, enemy_score unchanged.
REQ-032 target_killed on the timeout cycle -> FALLING entered, no escape_pulse, enemy_score unchanged.
REQ-033 game_enable dropped mid-FLYING, then re-raised -> IDLE, scores held; on re-raise enemy_score=0, round_num=0, relaunch 6 cycles later.
REQ-034 With DUCK_ROUND_SPEEDUP_EN and ROUNDS=4, no kills -> rounds 1-2 escape after 20 cycles, rounds 3-4 after 10 cycles; rst pulsed low mid-round -> all outputs 0 immediately.
